// File: rtl/exec_pkg.sv
// Shared types for the execution-stage functional units.
// Latency: none (types, constants and pure functions only).
// Backpressure: n/a.
package exec_pkg;

    localparam int MULT_MODE_W = 2;

    // Product select: low half, or high half under one of three signedness combinations
    typedef enum logic [MULT_MODE_W-1:0] {
        MUL_LO  = 2'd0,
        MULH_SS = 2'd1,
        MULH_UU = 2'd2,
        MULH_SU = 2'd3
    } mult_mode_e;

    // Multiplicand is treated as signed for the two signed high-half modes
    function automatic logic mode_op1_signed(input mult_mode_e mode);
        return (mode == MULH_SS) || (mode == MULH_SU);
    endfunction

    // Multiplier is treated as signed only when both operands are signed
    function automatic logic mode_op2_signed(input mult_mode_e mode);
        return (mode == MULH_SS);
    endfunction

endpackage

// File: rtl/mult_core.sv
// Combinational multiply with per-mode operand extension and product-half select.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers the result.
module mult_core
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  mult_mode_e       mode,
    output logic [WIDTH-1:0] res
);

    // Each operand is extended to WIDTH+1 bits by mode and then on to 2*WIDTH bits.
    // Only the low 2*WIDTH bits of the (WIDTH+1)x(WIDTH+1) signed product are ever
    // selected, and those bits are identical for a modulo-2^(2*WIDTH) multiply.
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic               a_sign;
    logic               b_sign;

    // Extend operands per mode, multiply, pick the requested half
    always_comb begin
        a_sign = mode_op1_signed(mode) & op1[WIDTH-1];
        b_sign = mode_op2_signed(mode) & op2[WIDTH-1];
        a_ext  = {{WIDTH{a_sign}}, op1};
        b_ext  = {{WIDTH{b_sign}}, op2};
        prod   = a_ext * b_ext;
        res    = (mode == MUL_LO) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/exec_mult_unit.sv
// Pipelined tagged multiplier unit: product formed at issue, then carried down STAGES slots.
// Latency: STAGES cycles issue-to-result with wb_ready held high; one op per cycle.
// Backpressure: wb_ready=0 with a valid result stalls every slot; mult_free drops; flush clears all.
module exec_mult_unit
    import exec_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3,
    parameter int TAG_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_en,
    input  logic [WIDTH-1:0] mult_op1,
    input  logic [WIDTH-1:0] mult_op2,
    input  mult_mode_e       mult_mode,
    input  logic [TAG_W-1:0] mult_tag,
    input  logic             flush,
    input  logic             wb_ready,
    output logic             mult_free,
    output logic             mult_valid_wb,
    output logic [WIDTH-1:0] mult_out,
    output logic [TAG_W-1:0] mult_tag_wb
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] res;
    } slot_t;

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    slot_t             slot_q [STAGES];
    slot_t             slot_d [STAGES];

    logic [WIDTH-1:0]  core_res;
    logic              advance;
    logic              accept;

    mult_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op1  (mult_op1),
        .op2  (mult_op2),
        .mode (mult_mode),
        .res  (core_res)
    );

    // Whole pipe moves together whenever the result slot is empty or being consumed
    always_comb begin
        advance   = !vld_q[LAST] || wb_ready;
        mult_free = advance && !flush;
        accept    = mult_en && mult_free;
    end

    // Next-state of slots: shift on advance, flush overrides both issue and stall
    always_comb begin
        vld_d  = vld_q;
        slot_d = slot_q;
        if (advance) begin
            vld_d[0]  = accept;
            slot_d[0] = '{tag: mult_tag, res: core_res};
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i]  = vld_q[i-1];
                slot_d[i] = slot_q[i-1];
            end
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    // Pipeline registers; reset discards all in-flight work and zeroes the outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            slot_q <= slot_d;
        end
    end

    // Result handoff comes straight from the final slot's registers
    always_comb begin
        mult_valid_wb = vld_q[LAST];
        mult_out      = slot_q[LAST].res;
        mult_tag_wb   = slot_q[LAST].tag;
    end

endmodule

// File: tb/tb_exec_mult_unit.sv
// Self-checking bench for exec_mult_unit: scoreboard of expected results plus scenario tasks.
// Latency: n/a.
// Backpressure: wb_ready driven directed or random to exercise stalls.
module tb_exec_mult_unit;
    import exec_pkg::*;

    localparam int W  = 16;
    localparam int ST = 3;
    localparam int TW = 6;

    logic          clk;
    logic          rst;
    logic          mult_en;
    logic [W-1:0]  mult_op1;
    logic [W-1:0]  mult_op2;
    mult_mode_e    mult_mode;
    logic [TW-1:0] mult_tag;
    logic          flush;
    logic          wb_ready;
    logic          mult_free;
    logic          mult_valid_wb;
    logic [W-1:0]  mult_out;
    logic [TW-1:0] mult_tag_wb;

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t exp_item;
    int   checks = 0;
    int   passes = 0;
    bit   rand_rdy = 0;

    exec_mult_unit #(
        .WIDTH  (W),
        .STAGES (ST),
        .TAG_W  (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mult_en       (mult_en),
        .mult_op1      (mult_op1),
        .mult_op2      (mult_op2),
        .mult_mode     (mult_mode),
        .mult_tag      (mult_tag),
        .flush         (flush),
        .wb_ready      (wb_ready),
        .mult_free     (mult_free),
        .mult_valid_wb (mult_valid_wb),
        .mult_out      (mult_out),
        .mult_tag_wb   (mult_tag_wb)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Arithmetic reference built on 64-bit integers with explicit two's-complement reinterpretation
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input mult_mode_e m);
        longint      av;
        longint      bv;
        logic [63:0] p;
        av = longint'(a);
        bv = longint'(b);
        if ((m == MULH_SS || m == MULH_SU) && a[W-1]) av = av - (longint'(1) << W);
        if (m == MULH_SS && b[W-1]) bv = bv - (longint'(1) << W);
        p = av * bv;
        if (m == MUL_LO) return p[W-1:0];
        return p[2*W-1:W];
    endfunction

    // Scoreboard: pop and compare on every handoff, push on every accepted issue
    always @(negedge clk) begin
        exp_t e;
        if (rst && mult_valid_wb && wb_ready) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected got res=%h tag=%0d, want no result", mult_out, mult_tag_wb);
            end else begin
                e = sb.pop_front();
                if (mult_out !== e.res || mult_tag_wb !== e.tag)
                    $display("FAIL sb_result got res=%h tag=%0d, want res=%h tag=%0d",
                             mult_out, mult_tag_wb, e.res, e.tag);
                else
                    passes++;
            end
        end
        if (rst && flush) sb.delete();
        else if (rst && mult_en && mult_free) sb.push_back(exp_item);
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) wb_ready = 1'($urandom_range(0, 1));
    endtask

    // Present one op and hold it until accepted
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input mult_mode_e m,
                         input logic [TW-1:0] t, input logic [W-1:0] e);
        bit done = 0;
        mult_op1     = a;
        mult_op2     = b;
        mult_mode    = m;
        mult_tag     = t;
        exp_item.res = e;
        exp_item.tag = t;
        mult_en      = 1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = mult_free;
            step();
        end
        mult_en = 0;
        if (!done) begin
            checks++;
            $display("FAIL issue_timeout op never accepted, want accepted within 200 cycles");
        end
    endtask

    // Issue one op with wb_ready=1 and count cycles until the result is visible
    task automatic timed_op(input logic [W-1:0] a, input logic [W-1:0] b, input mult_mode_e m,
                            input logic [TW-1:0] t, input logic [W-1:0] e, output int lat);
        wb_ready = 1;
        issue(a, b, m, t, e);
        lat = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mult_valid_wb) break;
            step();
            lat++;
        end
    endtask

    task automatic drain();
        rand_rdy = 0;
        wb_ready = 1;
        mult_en  = 0;
        for (int k = 0; k < 100 && (sb.size() != 0 || mult_valid_wb); k++) step();
        checks++;
        if (sb.size() != 0 || mult_valid_wb)
            $display("FAIL drain got %0d results outstanding, want 0", sb.size());
        else
            passes++;
    endtask

    task automatic test_reset();
        rst = 0;
        #1;
        checks += 4;
        if (mult_valid_wb !== 1'b0) $display("FAIL reset_valid got %b want 0", mult_valid_wb); else passes++;
        if (mult_out !== '0) $display("FAIL reset_out got %h want 0", mult_out); else passes++;
        if (mult_tag_wb !== '0) $display("FAIL reset_tag got %0d want 0", mult_tag_wb); else passes++;
        if (mult_free !== 1'b1) $display("FAIL reset_free got %b want 1", mult_free); else passes++;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        step();
    endtask

    task automatic test_basic();
        int lat;
        timed_op(W'(12), W'(15), MUL_LO, TW'(5), W'(16'h00B4), lat);
        checks += 3;
        if (lat !== ST) $display("FAIL basic_latency got %0d want %0d", lat, ST); else passes++;
        if (mult_out !== W'(16'h00B4)) $display("FAIL basic_out got %h want 00b4", mult_out); else passes++;
        if (mult_tag_wb !== TW'(5)) $display("FAIL basic_tag got %0d want 5", mult_tag_wb); else passes++;
        step();
        drain();
    endtask

    task automatic test_modes();
        wb_ready = 1;
        issue(16'hFFFD, 16'h0005, MUL_LO,  TW'(1), 16'hFFF1);
        issue(16'hFFFD, 16'h0005, MULH_SS, TW'(2), 16'hFFFF);
        issue(16'hFFFF, 16'hFFFF, MULH_UU, TW'(3), 16'hFFFE);
        issue(16'hFFFF, 16'hFFFF, MULH_SU, TW'(4), 16'hFFFF);
        issue(16'h8000, 16'h8000, MULH_SS, TW'(6), 16'h4000);
        issue(16'h8000, 16'h0002, MULH_SU, TW'(7), 16'hFFFF);
        drain();
    endtask

    task automatic test_back_to_back();
        int           acc = 0;
        int           want_acc;
        logic [W-1:0] held;
        logic [W-1:0] a;
        logic [W-1:0] b;
        mult_mode_e   m;
        want_acc = (ST < 5) ? ST : 5;
        wb_ready = 1;
        for (int c = 0; c < 40 && (acc < 5 || c < 12); c++) begin
            if (acc < 5) begin
                a = W'(acc * 1031 + 7);
                b = W'(acc * 977 + 3);
                m = mult_mode_e'(acc % 4);
                mult_op1 = a; mult_op2 = b; mult_mode = m; mult_tag = TW'(acc + 10);
                exp_item.res = ref_mul(a, b, m);
                exp_item.tag = TW'(acc + 10);
                mult_en = 1;
            end else begin
                mult_en = 0;
            end
            @(negedge clk);
            if (mult_en && mult_free) acc++;
            step();
            if (c == 0) wb_ready = 0;
            if (c == 11) begin
                checks += 3;
                if (acc !== want_acc) $display("FAIL bp_accepted got %0d want %0d", acc, want_acc); else passes++;
                if (mult_free !== 1'b0) $display("FAIL bp_free got %b want 0", mult_free); else passes++;
                if (mult_valid_wb !== 1'b1) $display("FAIL bp_valid got %b want 1", mult_valid_wb); else passes++;
                held = mult_out;
                step();
                step();
                checks++;
                if (mult_out !== held || mult_valid_wb !== 1'b1)
                    $display("FAIL bp_stable got %h/%b want %h/1", mult_out, mult_valid_wb, held);
                else
                    passes++;
                wb_ready = 1;
            end
        end
        mult_en = 0;
        drain();
    endtask

    task automatic test_flush();
        int seen = 0;
        int lat;
        wb_ready = 0;
        for (int i = 0; i < 3; i++)
            issue(W'(i + 2), W'(i + 9), MUL_LO, TW'(20 + i), ref_mul(W'(i + 2), W'(i + 9), MUL_LO));
        mult_op1 = W'(33); mult_op2 = W'(44); mult_mode = MUL_LO; mult_tag = TW'(30);
        exp_item.res = ref_mul(W'(33), W'(44), MUL_LO);
        exp_item.tag = TW'(30);
        mult_en = 1;
        flush   = 1;
        @(negedge clk);
        checks++;
        if (mult_free !== 1'b0) $display("FAIL flush_free got %b want 0", mult_free); else passes++;
        step();
        flush    = 0;
        mult_en  = 0;
        wb_ready = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mult_valid_wb) seen++;
            step();
        end
        checks++;
        if (seen != 0) $display("FAIL flush_results got %0d results want 0", seen); else passes++;
        timed_op(W'(300), W'(7), MUL_LO, TW'(31), W'(2100), lat);
        checks += 2;
        if (lat !== ST) $display("FAIL flush_next_latency got %0d want %0d", lat, ST); else passes++;
        if (mult_out !== W'(2100)) $display("FAIL flush_next_out got %h want %h", mult_out, W'(2100)); else passes++;
        step();
        drain();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        wb_ready = 0;
        issue(W'(100), W'(7), MUL_LO, TW'(40), W'(700));
        issue(W'(9), W'(9), MUL_LO, TW'(41), W'(81));
        for (int k = 0; k < 20 && !mult_valid_wb; k++) step();
        checks++;
        if (mult_valid_wb !== 1'b1 || mult_out !== W'(700))
            $display("FAIL rstmid_pre got %b/%h want 1/%h", mult_valid_wb, mult_out, W'(700));
        else
            passes++;
        rst = 0;
        #1;
        checks += 3;
        if (mult_valid_wb !== 1'b0) $display("FAIL rstmid_valid got %b want 0", mult_valid_wb); else passes++;
        if (mult_out !== '0) $display("FAIL rstmid_out got %h want 0", mult_out); else passes++;
        if (mult_tag_wb !== '0) $display("FAIL rstmid_tag got %0d want 0", mult_tag_wb); else passes++;
        sb.delete();
        step();
        rst      = 1;
        wb_ready = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mult_valid_wb) seen++;
            step();
        end
        checks++;
        if (seen != 0) $display("FAIL rstmid_results got %0d want 0", seen); else passes++;
    endtask

    task automatic test_random();
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        mult_mode_e    m;
        logic [TW-1:0] t;
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            m = mult_mode_e'($urandom_range(0, 3));
            t = TW'($urandom_range(0, (1 << TW) - 1));
            issue(a, b, m, t, ref_mul(a, b, m));
        end
        drain();
    endtask

    initial begin
        mult_en   = 0;
        mult_op1  = '0;
        mult_op2  = '0;
        mult_mode = MUL_LO;
        mult_tag  = '0;
        flush     = 0;
        wb_ready  = 0;
        exp_item.res = '0;
        exp_item.tag = '0;
        test_reset();
        test_basic();
        test_modes();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation ran past 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
